// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Optional build macro UART_TX_PARITY_EN is consumed in uart_tx_periph.sv.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

    localparam logic [3:0] UART_WINDOW = 4'h1;

endpackage

// File: rtl/uart_tx_periph_if.sv
// BIU branch-3 bus bundle: address, write data, byte enables and read data.
interface uart_tx_periph_if;

    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    modport master (
        output daddr,
        output dwdata,
        output dwe,
        input  drdata
    );

    modport slave (
        input  daddr,
        input  dwdata,
        input  dwe,
        output drdata
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only alongside a pop.
module uart_tx_fifo #(
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW         = $clog2(FIFO_DEPTH),
    localparam int unsigned CW         = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte FIFO, baud divider and 8N1 shift FSM.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_periph_if.slave  bus,
    output logic             txd,
    output logic             irq_empty
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    offset;
    logic          wr;
    logic          push_req;
    logic          ovf_clr;
    logic [15:0]   baud_div;
    logic          overflow;
    logic [31:0]   status_word;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_e     state;
    tx_state_e     state_next;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          busy;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.daddr[31:20], bus.daddr[15:4], bus.daddr[1:0],
                           bus.dwdata[31:16]};

    assign sel      = (bus.daddr[19:16] == UART_WINDOW);
    assign offset   = bus.daddr[3:2];
    assign wr       = sel && (bus.dwe != '0);
    assign push_req = wr && (offset == OFF_DATA) && bus.dwe[0];
    assign ovf_clr  = wr && (offset == OFF_STATUS) && bus.dwe[0] && bus.dwdata[STAT_OVF];
    assign busy     = (state != IDLE);
    assign tick     = (baud_cnt == '0);

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (bus.dwdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr && (offset == OFF_BAUD)) begin
                if (bus.dwe[0]) baud_div[7:0]  <= bus.dwdata[7:0];
                if (bus.dwe[1]) baud_div[15:8] <= bus.dwdata[15:8];
            end
            // A pop in the same cycle makes room, so that push is not an overflow.
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[STAT_BUSY]        = busy;
        status_word[STAT_FULL]        = fifo_full;
        status_word[STAT_EMPTY]       = fifo_empty;
        status_word[STAT_OVF]         = overflow;
        status_word[STAT_CNT_LSB +: 4] = 4'(fifo_count);
    end

    always_comb begin
        bus.drdata = '0;
        if (sel) begin
            case (offset)
                OFF_STATUS: bus.drdata = status_word;
                OFF_BAUD:   bus.drdata = {16'h0000, baud_div};
                default:    bus.drdata = '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    fifo_pop   = 1'b1;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The bit counter reloads from baud_div at every bit boundary, so a BAUD
    // write during a frame only affects bits that start after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state <= state_next;
            if (fifo_pop) begin
                shreg    <= fifo_dout;
                baud_cnt <= baud_div;
                bit_idx  <= '0;
            end else if (state != IDLE) begin
                if (tick) begin
                    baud_cnt <= baud_div;
                    if (state == DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (fifo_pop) begin
            par_bit <= ^fifo_dout;
        end
    end
`endif

    always_comb begin
        txd = 1'b1;
        case (state)
            START: txd = 1'b0;
            DATA:  txd = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd = par_bit;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_empty <= 1'b1;
        end else begin
            irq_empty <= fifo_empty && (state == IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: register table, exact frame timing,
// overflow behaviour, randomized bursts decoded by a UART receiver model.
module tb_uart_tx_periph;

    localparam logic [31:0] A_DATA = 32'h0001_0000;
    localparam logic [31:0] A_STAT = 32'h0001_0004;
    localparam logic [31:0] A_BAUD = 32'h0001_0008;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic txd;
    logic irq_empty;

    uart_tx_periph_if bif ();

    uart_tx_periph #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .txd       (txd),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic        rec[$];
    bit          rec_en  = 1'b0;
    bit          rec_clr = 1'b0;
    logic [7:0]  dec_q[$];
    logic [7:0]  exp_q[$];
    int unsigned starts[$];
    int unsigned frame_err;

    always @(negedge clk) begin
        if (rec_clr) rec.delete();
        else if (rec_en) rec.push_back(txd);
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       nm;
    } rd_vec_t;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Level of frame bit k: start, 8 data bits LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NBITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // UART receiver model over the recorded txd samples (one per clock).
    function automatic void decode(input int unsigned div);
        int unsigned p    = div + 1;
        int unsigned flen = NBITS * p;
        int unsigned s    = 1;
        logic [7:0]  b;
        dec_q.delete();
        starts.delete();
        frame_err = 0;
        while (s + flen <= rec.size()) begin
            if (rec[s] === 1'b0 && rec[s-1] === 1'b1) begin
                for (int j = 0; j < 8; j++) b[j] = rec[s + (j + 1) * p + p / 2];
                if (rec[s + p / 2] !== 1'b0) frame_err++;
                if (rec[s + (NBITS - 1) * p + p / 2] !== 1'b1) frame_err++;
                if (NBITS == 11 && rec[s + 9 * p + p / 2] !== ^b) frame_err++;
                dec_q.push_back(b);
                starts.push_back(s);
                s += flen;
            end else begin
                s++;
            end
        end
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bif.daddr  = a;
        bif.dwdata = d;
        bif.dwe    = be;
        @(posedge clk);
        #1;
        bif.dwe   = 4'b0000;
        bif.daddr = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bif.daddr = a;
        bif.dwe   = 4'b0000;
        #1;
        d = bif.drdata;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        bus_read(a, d);
        check(nm, d, exp);
    endtask

    // Waits for the start bit, then checks every cycle of the frame.
    task automatic expect_frame(input int unsigned div, input logic [7:0] b,
                                input int unsigned exp_lat, input string nm);
        int unsigned lat  = 0;
        int unsigned bad  = 0;
        bit          seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
            if (txd === 1'b0) seen = 1'b1;
        end
        check({nm, " start seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            if (exp_lat != 0) check({nm, " start latency"}, lat, exp_lat);
            for (int unsigned i = 1; i < NBITS * (div + 1); i++) begin
                @(negedge clk);
                #1;
                if (txd !== frame_bit(b, i / (div + 1))) bad++;
            end
            check({nm, " frame cycles wrong"}, bad, 32'd0);
            @(negedge clk);
            #1;
            check({nm, " idle after stop"}, {31'b0, txd}, 32'd1);
        end
    endtask

    task automatic compare_bytes(input string nm);
        check({nm, " frame errors"}, frame_err, 32'd0);
        check({nm, " byte count"}, dec_q.size(), exp_q.size());
        for (int i = 0; i < dec_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s byte %0d", nm, i), {24'b0, dec_q[i]}, {24'b0, exp_q[i]});
        end
    endtask

    rd_vec_t rv[8];

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int unsigned div;
        int unsigned n;
        int unsigned zeros;
        bit          seen;

        bif.daddr  = 32'h0;
        bif.dwdata = 32'h0;
        bif.dwe    = 4'b0000;

        rv[0] = '{32'h0001_0004, 32'h0000_0004, "reset STATUS"};
        rv[1] = '{32'h0001_0008, 32'd867,       "reset BAUD"};
        rv[2] = '{32'h0001_0000, 32'h0,         "DATA reads 0"};
        rv[3] = '{32'h0001_000C, 32'h0,         "offset 3 reads 0"};
        rv[4] = '{32'h0003_4564, 32'h0,         "sel low 0x00034564"};
        rv[5] = '{32'h0000_0010, 32'h0,         "sel low 0x00000010"};
        rv[6] = '{32'hFFF1_FFF4, 32'h0000_0004, "STATUS alias high bits"};
        rv[7] = '{32'h0011_0008, 32'd867,       "BAUD alias high bits"};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset txd", {31'b0, txd}, 32'd1);
        check("reset irq_empty", {31'b0, irq_empty}, 32'd1);
        for (int i = 0; i < 8; i++) read_check(rv[i].addr, rv[i].exp, rv[i].nm);

        // BAUD byte lanes
        bus_write(A_BAUD, 32'h0000_AB00, 4'b0010);
        read_check(A_BAUD, 32'h0000_AB63, "BAUD upper lane");
        bus_write(A_BAUD, 32'h1234_5603, 4'b0001);
        read_check(A_BAUD, 32'h0000_AB03, "BAUD lower lane");
        bus_write(A_BAUD, 32'h0000_0000, 4'b0000);
        read_check(A_BAUD, 32'h0000_AB03, "BAUD dwe=0 ignored");

        // Writes that must not push
        bus_write(A_DATA, 32'h0000_00AA, 4'b0000);
        bus_write(A_DATA, 32'h0000_00AA, 4'b0010);
        bus_write(32'h0002_0000, 32'h0000_00AA, 4'b1111);
        repeat (3) @(negedge clk);
        read_check(A_STAT, 32'h0000_0004, "no push without dwe[0]/sel");
        check("txd idle without push", {31'b0, txd}, 32'd1);

        // Directed 0x55 frame with baud_div=3
        bus_write(A_BAUD, 32'd3, 4'b0011);
        bus_write(A_DATA, 32'h0000_0055, 4'b0001);
        read_check(A_STAT, 32'h0000_0010, "STATUS after push");
        check("txd before pop", {31'b0, txd}, 32'd1);
        expect_frame(3, 8'h55, 1, "frame 0x55");
        read_check(A_STAT, 32'h0000_0004, "STATUS after frame");
        check("irq_empty after frame", {31'b0, irq_empty}, 32'd1);

        // Overflow: baud_div=100, fill the FIFO behind one frame in flight
        bus_write(A_BAUD, 32'd100, 4'b0011);
        rec_clr = 1'b1;
        @(negedge clk);
        #1 rec_clr = 1'b0;
        rec_en = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(A_DATA, {24'b0, b}, 4'b0001);
        end
        read_check(A_STAT, 32'h0000_0083, "STATUS full, no overflow");
        check("irq_empty low while busy", {31'b0, irq_empty}, 32'd0);
        bus_write(A_DATA, 32'h0000_00EE, 4'b0001);
        read_check(A_STAT, 32'h0000_008B, "STATUS overflow set");
        bus_write(A_STAT, 32'h0000_0000, 4'b0001);
        read_check(A_STAT, 32'h0000_008B, "overflow sticky");
        bus_write(A_STAT, 32'h0000_0008, 4'b0001);
        read_check(A_STAT, 32'h0000_0083, "overflow cleared");
        repeat (9 * (NBITS * 101 + 1) + 50) @(negedge clk);
        rec_en = 1'b0;
        decode(100);
        compare_bytes("overflow burst");
        for (int i = 1; i < starts.size(); i++) begin
            check($sformatf("frame gap %0d", i), starts[i] - starts[i-1], NBITS * 101 + 1);
        end
        read_check(A_STAT, 32'h0000_0004, "STATUS after burst");

        // Randomized bursts (at most 9 bytes, none can be dropped)
        for (int r = 0; r < 6; r++) begin
            div = $urandom_range(0, 6);
            bus_write(A_BAUD, div, 4'b0011);
            rec_clr = 1'b1;
            @(negedge clk);
            #1 rec_clr = 1'b0;
            rec_en = 1'b1;
            exp_q.delete();
            n = $urandom_range(1, 9);
            for (int unsigned i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(A_DATA, {24'b0, b}, 4'b0001);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            repeat (n * (NBITS * (div + 1) + 1) + 30) @(negedge clk);
            rec_en = 1'b0;
            decode(div);
            compare_bytes($sformatf("random round %0d", r));
            read_check(A_STAT, 32'h0000_0004, $sformatf("random round %0d STATUS", r));
        end

        // Reset during DATA bit 3 of 0xF0 with a second byte still queued
        bus_write(A_BAUD, 32'd3, 4'b0011);
        bus_write(A_DATA, 32'h0000_00F0, 4'b0001);
        bus_write(A_DATA, 32'h0000_0033, 4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (txd === 1'b0) seen = 1'b1;
        end
        check("reset test start seen", {31'b0, seen}, 32'd1);
        repeat (17) @(negedge clk);
        #1;
        check("txd in DATA bit 3", {31'b0, txd}, 32'd0);
        reset     = 1'b1;
        bif.daddr = A_STAT;
        @(negedge clk);
        #1;
        check("txd after mid-frame reset", {31'b0, txd}, 32'd1);
        check("STATUS after mid-frame reset", bif.drdata, 32'h0000_0004);
        reset  = 1'b0;
        rec_clr = 1'b1;
        @(negedge clk);
        #1 rec_clr = 1'b0;
        rec_en = 1'b1;
        repeat (200) @(negedge clk);
        rec_en = 1'b0;
        zeros = 0;
        foreach (rec[i]) if (rec[i] !== 1'b1) zeros++;
        check("no residual frame", zeros, 32'd0);
        read_check(A_STAT, 32'h0000_0004, "STATUS idle after reset");
        read_check(A_BAUD, 32'd867, "BAUD back to default");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
